// File: rtl/vga_pkg.sv
// Shared VGA timing/geometry constants and sprite motion defaults.
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int SPR_W_DEF = 32;
  localparam int SPR_H_DEF = 16;

  localparam int X_MAX = H_ACTIVE - SPR_W_DEF;  // 608
  localparam int Y_MAX = V_ACTIVE - SPR_H_DEF;  // 464

  localparam logic [9:0] X_RST = 10'(X_MAX / 2);  // 304
  localparam logic [9:0] Y_RST = 10'(Y_MAX / 2);  // 232

  localparam int NUM_AX = 2;
  localparam int AX_X   = 0;
  localparam int AX_Y   = 1;

  // Travel limit for a sprite of the given size on the given active extent.
  function automatic int axis_max(input int active, input int size);
    return active - size;
  endfunction

  // Reset position: the middle of the legal travel range.
  function automatic logic [9:0] axis_centre(input int active, input int size);
    return 10'((active - size) / 2);
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// Next position/direction/hit for one sprite axis; bounce by default,
// wrap-around when SPRITE_WRAP_EN is defined.
module sprite_axis_step
  import vga_pkg::*;
#(
  parameter int MAX = X_MAX
) (
  input  logic [9:0] pos,
  input  logic       dir,
  input  logic       run,
  input  logic [2:0] speed,
  output logic [9:0] nxt_pos,
  output logic       nxt_dir,
  output logic       hit
);

  localparam logic [10:0] MAX11 = 11'(MAX);

  logic [10:0] pos11, spd11, sum11;

  assign pos11 = {1'b0, pos};
  assign spd11 = {8'd0, speed};
  assign sum11 = pos11 + spd11;

  always_comb begin
    nxt_pos = pos;
    nxt_dir = dir;
    hit     = 1'b0;
    if (run && (speed != 3'd0)) begin
`ifdef SPRITE_WRAP_EN
      if (dir) begin
        if (sum11 > MAX11) begin
          nxt_pos = 10'(sum11 - (MAX11 + 11'd1));
          hit     = 1'b1;
        end else begin
          nxt_pos = sum11[9:0];
        end
      end else if (pos11 < spd11) begin
        nxt_pos = 10'(pos11 + MAX11 + 11'd1 - spd11);
        hit     = 1'b1;
      end else begin
        nxt_pos = 10'(pos11 - spd11);
      end
`else
      if (dir) begin
        if (sum11 >= MAX11) begin
          nxt_pos = MAX11[9:0];
          nxt_dir = 1'b0;
          hit     = 1'b1;
        end else begin
          nxt_pos = sum11[9:0];
        end
      end else if (pos11 < spd11) begin
        // also covers pos == 0 with a non-zero speed
        nxt_pos = 10'd0;
        nxt_dir = 1'b1;
        hit     = 1'b1;
      end else begin
        nxt_pos = 10'(pos11 - spd11);
      end
`endif
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite mover: vsync falling-edge tick, two axis steppers,
// output registers. Define SPRITE_WRAP_EN for wrap-around instead of bounce.
module sprite_motion_ctrl
  import vga_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       vsync,
  input  logic       run,
  input  logic [2:0] speed,
  output logic [9:0] spr_x,
  output logic [9:0] spr_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       frame_tick,
  output logic [1:0] hit
);

  localparam logic [9:0] X_C = axis_centre(H_ACTIVE, SPR_W);
  localparam logic [9:0] Y_C = axis_centre(V_ACTIVE, SPR_H);

  logic                        vsync_d;
  logic                        armed;
  logic                        frame_edge;
  logic [NUM_AX-1:0][9:0]      pos_q, pos_nxt;
  logic [NUM_AX-1:0]           dir_q, dir_nxt, hit_nxt;

  // armed blocks a tick from a vsync that was already low when reset released
  assign frame_edge = armed & vsync_d & ~vsync;

  for (genvar a = 0; a < NUM_AX; a++) begin : g_axis
    localparam int MAX = (a == AX_X) ? axis_max(H_ACTIVE, SPR_W)
                                     : axis_max(V_ACTIVE, SPR_H);
    sprite_axis_step #(.MAX(MAX)) u_step (
      .pos     (pos_q[a]),
      .dir     (dir_q[a]),
      .run     (run),
      .speed   (speed),
      .nxt_pos (pos_nxt[a]),
      .nxt_dir (dir_nxt[a]),
      .hit     (hit_nxt[a])
    );
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      vsync_d    <= 1'b1;
      armed      <= 1'b0;
      frame_tick <= 1'b0;
      hit        <= '0;
      pos_q      <= {Y_C, X_C};
      dir_q      <= '1;
    end else begin
      vsync_d    <= vsync;
      armed      <= armed | vsync;
      frame_tick <= frame_edge;
      hit        <= frame_edge ? hit_nxt : '0;
      if (frame_edge) begin
        pos_q <= pos_nxt;
        dir_q <= dir_nxt;
      end
    end
  end

  assign spr_x = pos_q[AX_X];
  assign spr_y = pos_q[AX_Y];
  assign dir_x = dir_q[AX_X];
  assign dir_y = dir_q[AX_Y];

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: randomized frames against a
// behavioural bounce/wrap model, plus directed edge and reset scenarios.
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       vsync = 1'b1;
  logic       run = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [9:0] spr_x, spr_y;
  logic       dir_x, dir_y, frame_tick;
  logic [1:0] hit;

  sprite_motion_ctrl dut (
    .clk(clk), .clr(clr), .vsync(vsync), .run(run), .speed(speed),
    .spr_x(spr_x), .spr_y(spr_y), .dir_x(dir_x), .dir_y(dir_y),
    .frame_tick(frame_tick), .hit(hit)
  );

  always #20 clk = ~clk;

  typedef struct {
    int       x, y;
    bit       dx, dy;
    bit [1:0] h;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ticks  = 0;
  int   mx, my;
  bit   mdx, mdy;
  bit   vs_prev;
  exp_t cur;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: one axis advanced by one frame, straight from the motion rules.
  function automatic void step(input int pos, input bit dir, input int lim,
                               input bit r, input int s,
                               output int np, output bit nd, output bit h);
    np = pos; nd = dir; h = 1'b0;
    if (!r || s == 0) return;
`ifdef SPRITE_WRAP_EN
    if (dir) begin
      if (pos + s > lim) begin np = pos + s - (lim + 1); h = 1'b1; end
      else np = pos + s;
    end else begin
      if (pos < s) begin np = pos + (lim + 1) - s; h = 1'b1; end
      else np = pos - s;
    end
`else
    if (dir) begin
      if (pos + s >= lim) begin np = lim; nd = 1'b0; h = 1'b1; end
      else np = pos + s;
    end else begin
      if (pos < s) begin np = 0; nd = 1'b1; h = 1'b1; end
      else np = pos - s;
    end
`endif
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // One clock of stimulus; a genuine 1->0 vsync edge schedules a model update.
  task automatic drive(input bit v, input bit r, input int s);
    exp_t e;
    bit hx, hy;
    vsync = v; run = r; speed = 3'(s);
    if (vs_prev && !v) begin
      step(mx, mdx, 608, r, s, mx, mdx, hx);
      step(my, mdy, 464, r, s, my, mdy, hy);
      e.x = mx; e.y = my; e.dx = mdx; e.dy = mdy; e.h = {hy, hx};
      q.push_back(e);
    end
    vs_prev = v;
    cyc();
  endtask

  // vsync high for hi cycles with junk run/speed, then the sampling cycle.
  // Returns positioned in the tick cycle.
  task automatic frame(input bit r, input int s, input int hi);
    for (int i = 0; i < hi; i++) drive(1'b1, 1'($urandom), int'($urandom_range(0, 7)));
    drive(1'b0, r, s);
  endtask

  task automatic tail(input int lo);
    for (int i = 0; i < lo; i++) drive(1'b0, 1'($urandom), int'($urandom_range(0, 7)));
  endtask

  task automatic do_reset(input bit vs_rel);
    clr = 1'b1;
    q.delete();
    repeat (3) cyc();
    mx = 304; my = 232; mdx = 1'b1; mdy = 1'b1;
    vs_prev = 1'b0;
    vsync = vs_rel;
    clr = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every tick, otherwise checks hold/quiet.
  always @(negedge clk) begin
    if (clr) begin
      chk("rst_out", {spr_x, spr_y, dir_x, dir_y, frame_tick, hit},
          {10'd304, 10'd232, 1'b1, 1'b1, 1'b0, 2'b00});
      cur.x = 304; cur.y = 232; cur.dx = 1'b1; cur.dy = 1'b1; cur.h = 2'b00;
    end else if (frame_tick) begin
      ticks++;
      if (q.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        cur = q.pop_front();
        chk("tick_x", int'(spr_x), cur.x);
        chk("tick_y", int'(spr_y), cur.y);
        chk("tick_dir", {dir_x, dir_y}, {cur.dx, cur.dy});
        chk("tick_hit", int'(hit), int'(cur.h));
      end
    end else begin
      chk("idle_hit", int'(hit), 0);
      chk("idle_hold", {spr_x, spr_y, dir_x, dir_y},
          {10'(cur.x), 10'(cur.y), cur.dx, cur.dy});
    end
  end

  initial begin
    int sx, sy, t0;
    cyc();
    do_reset(1'b1);

    // first frame after reset: speed 3 moves both axes up by 3
    frame(1'b1, 3, 2);
    chk("first_tick", frame_tick, 1);
    chk("first_x", int'(spr_x), 307);
    chk("first_y", int'(spr_y), 235);
    tail(1);
    chk("tick_one_cycle", frame_tick, 0);

    do_reset(1'b1);
    repeat (42) begin frame(1'b1, 7, 1); tail(1); end
    frame(1'b1, 4, 1); tail(1);
`ifdef SPRITE_WRAP_EN
    frame(1'b1, 5, 1); tail(1);
    chk("pre_wrap_x", int'(spr_x), 607);
    frame(1'b1, 4, 2);
    chk("wrap_x", int'(spr_x), 2);
    chk("wrap_dir_x", dir_x, 1);
    chk("wrap_hit_x", hit[0], 1);
`else
    frame(1'b1, 4, 1); tail(1);
    chk("pre_bounce_x", int'(spr_x), 606);
    frame(1'b1, 5, 2);
    chk("bounce_x", int'(spr_x), 608);
    chk("bounce_dir_x", dir_x, 0);
    chk("bounce_hit_x", hit[0], 1);
`endif
    tail(1);
    chk("hit_clears", int'(hit), 0);

    // frozen for three frames: ticks continue, nothing moves
    sx = int'(spr_x); sy = int'(spr_y); t0 = ticks;
    repeat (3) begin frame(1'b0, int'($urandom_range(1, 7)), 2); tail(2); end
    chk("freeze_ticks", ticks - t0, 3);
    chk("freeze_x", int'(spr_x), sx);
    chk("freeze_y", int'(spr_y), sy);

    // randomized frames
    repeat (1500) begin
      frame(1'($urandom_range(0, 4) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(1, 3)));
      tail(int'($urandom_range(1, 3)));
    end

    // reset in the middle of the vsync-high period
    drive(1'b1, 1'b1, 5);
    #4 clr = 1'b1;
    #1;
    chk("midframe_rst_x", int'(spr_x), 304);
    chk("midframe_rst_y", int'(spr_y), 232);
    do_reset(1'b1);
    repeat (5) begin frame(1'b1, 6, 1); tail(1); end

    // reset landing in the tick cycle; release with vsync already low
    frame(1'b1, 7, 2);
    #2 clr = 1'b1;
    #1;
    chk("midtick_rst_pos", {spr_x, spr_y}, {10'd304, 10'd232});
    chk("midtick_rst_tick", {frame_tick, hit}, 3'b000);
    do_reset(1'b0);
    t0 = ticks;
    tail(4);
    chk("no_tick_low_release", ticks - t0, 0);
    frame(1'b1, 1, 2);
    chk("tick_after_release", frame_tick, 1);
    chk("x_after_release", int'(spr_x), 305);
    tail(2);

    repeat (3) drive(1'b1, 1'b0, 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
